// File: rtl/compare_debouncer.sv
// rtl/compare_debouncer.sv - debounced A>B alarm with hysteresis from comparator G/E/L codes
// Also flags malformed comparator codes and counts alarm rises, saturating.
module compare_debouncer #(
    parameter int N_ASSERT   = 4,
    parameter int N_DEASSERT = 4,
    parameter int EVT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             G,
    input  logic             E,
    input  logic             L,
    input  logic             clr,
    output logic             alarm,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic             err,
    output logic [EVT_W-1:0] event_count
);

    if (N_ASSERT < 1 || N_ASSERT > 255) begin : g_bad_n_assert
        $error("compare_debouncer: N_ASSERT must be in 1..255");
    end
    if (N_DEASSERT < 1 || N_DEASSERT > 255) begin : g_bad_n_deassert
        $error("compare_debouncer: N_DEASSERT must be in 1..255");
    end
    if (EVT_W < 1) begin : g_bad_evt_w
        $error("compare_debouncer: EVT_W must be at least 1");
    end

    localparam logic [7:0]       L_NA      = 8'(N_ASSERT);
    localparam logic [7:0]       L_ND      = 8'(N_DEASSERT);
    localparam logic [EVT_W-1:0] L_EVT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMING    = 2'd1,
        ALARM     = 2'd2,
        DISARMING = 2'd3
    } state_t;

    state_t           r_state;
    logic [7:0]       r_cnt;
    logic             r_alarm;
    logic             r_rise;
    logic             r_fall;
    logic             r_err;
    logic [EVT_W-1:0] r_evt;

    logic       w_onehot;
    logic       w_hit;
    logic       w_miss;
    logic       w_bad;
    logic [7:0] w_cnt_inc;
    logic       w_rise;
    logic       w_fall;

    assign w_onehot  = ({G, E, L} == 3'b100) || ({G, E, L} == 3'b010) || ({G, E, L} == 3'b001);
    assign w_hit     = in_valid && w_onehot && G;
    assign w_miss    = in_valid && w_onehot && !G;
    assign w_bad     = in_valid && !w_onehot;
    assign w_cnt_inc = r_cnt + 8'd1;

    // Transition decisions are shared by the FSM, the pulse registers and the event counter.
    assign w_rise = w_hit && (((r_state == IDLE) && (L_NA == 8'd1)) ||
                              ((r_state == ARMING) && (w_cnt_inc == L_NA)));
    assign w_fall = w_miss && (((r_state == ALARM) && (L_ND == 8'd1)) ||
                               ((r_state == DISARMING) && (w_cnt_inc == L_ND)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
            r_alarm <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= w_rise;
            r_fall <= w_fall;
            if (w_rise) begin
                r_state <= ALARM;
                r_cnt   <= 8'd0;
                r_alarm <= 1'b1;
            end else if (w_fall) begin
                r_state <= IDLE;
                r_cnt   <= 8'd0;
                r_alarm <= 1'b0;
            end else if (w_hit || w_miss) begin
                unique case (r_state)
                    IDLE: begin
                        r_state <= w_hit ? ARMING : IDLE;
                        r_cnt   <= w_hit ? 8'd1 : 8'd0;
                    end
                    ARMING: begin
                        r_state <= w_hit ? ARMING : IDLE;
                        r_cnt   <= w_hit ? w_cnt_inc : 8'd0;
                    end
                    ALARM: begin
                        r_state <= w_miss ? DISARMING : ALARM;
                        r_cnt   <= w_miss ? 8'd1 : 8'd0;
                    end
                    DISARMING: begin
                        r_state <= w_miss ? DISARMING : ALARM;
                        r_cnt   <= w_miss ? w_cnt_inc : 8'd0;
                    end
                endcase
            end
        end
    end

    // A malformed sample outranks clr so a coincident fault is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
            r_evt <= '0;
        end else begin
            if (w_bad) begin
                r_err <= 1'b1;
            end else if (clr) begin
                r_err <= 1'b0;
            end
            if (clr) begin
                r_evt <= w_rise ? EVT_W'(1) : '0;
            end else if (w_rise && (r_evt != L_EVT_MAX)) begin
                r_evt <= r_evt + EVT_W'(1);
            end
        end
    end

    assign alarm       = r_alarm;
    assign rise_pulse  = r_rise;
    assign fall_pulse  = r_fall;
    assign err         = r_err;
    assign event_count = r_evt;

endmodule

// File: tb/tb_compare_debouncer.sv
// tb/tb_compare_debouncer.sv - directed and randomized bench for compare_debouncer
// Expected values come from a run-length model of the alarm hysteresis rules.
module tb_compare_debouncer;

    localparam int NA    = 4;
    localparam int ND    = 4;
    localparam int EVT_W = 8;
    localparam int EMAX  = (1 << EVT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             G = 1'b0;
    logic             E = 1'b0;
    logic             L = 1'b0;
    logic             clr = 1'b0;
    logic             alarm;
    logic             rise_pulse;
    logic             fall_pulse;
    logic             err;
    logic [EVT_W-1:0] event_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: alarm level, length of the current qualifying run, pulses, sticky error, event count.
    bit m_alarm = 0;
    int m_run   = 0;
    bit m_rise  = 0;
    bit m_fall  = 0;
    bit m_err   = 0;
    int m_evt   = 0;

    compare_debouncer #(.N_ASSERT(NA), .N_DEASSERT(ND), .EVT_W(EVT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .G(G), .E(E), .L(L), .clr(clr),
        .alarm(alarm), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .err(err),
        .event_count(event_count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_alarm = 0; m_run = 0; m_rise = 0; m_fall = 0; m_err = 0; m_evt = 0;
    endtask

    task automatic model_step(input bit v, input bit g, input bit e, input bit l, input bit c);
        int ones;
        bit rose;
        ones = int'(g) + int'(e) + int'(l);
        rose = 0;
        m_rise = 0;
        m_fall = 0;
        if (v && ones == 1) begin
            // Count samples that argue for changing the alarm; any opposing sample resets the run.
            if (g != m_alarm) begin
                m_run = m_run + 1;
                if (m_run == (m_alarm ? ND : NA)) begin
                    m_alarm = !m_alarm;
                    m_run   = 0;
                    if (m_alarm) rose = 1; else m_fall = 1;
                end
            end else begin
                m_run = 0;
            end
        end
        m_rise = rose;
        if (v && ones != 1) m_err = 1;
        else if (c) m_err = 0;
        if (c) m_evt = rose ? 1 : 0;
        else if (rose && m_evt < EMAX) m_evt = m_evt + 1;
    endtask

    task automatic check_outputs(input string tag);
        n_tests += 5;
        assert (alarm === m_alarm) else begin
            n_fail++; $error("FAIL %s alarm obs=%0b exp=%0b", tag, alarm, m_alarm);
        end
        assert (rise_pulse === m_rise) else begin
            n_fail++; $error("FAIL %s rise_pulse obs=%0b exp=%0b", tag, rise_pulse, m_rise);
        end
        assert (fall_pulse === m_fall) else begin
            n_fail++; $error("FAIL %s fall_pulse obs=%0b exp=%0b", tag, fall_pulse, m_fall);
        end
        assert (err === m_err) else begin
            n_fail++; $error("FAIL %s err obs=%0b exp=%0b", tag, err, m_err);
        end
        assert (int'(event_count) === m_evt) else begin
            n_fail++; $error("FAIL %s event_count obs=%0d exp=%0d", tag, event_count, m_evt);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then check just after the rising edge.
    task automatic step(input bit v, input bit g, input bit e, input bit l, input bit c,
                        input string tag);
        in_valid = v; G = g; E = e; L = l; clr = c;
        @(posedge clk);
        if (rst_n) model_step(v, g, e, l, c);
        #1;
        check_outputs(tag);
        @(negedge clk);
    endtask

    task automatic hit(input string tag);   step(1, 1, 0, 0, 0, tag); endtask
    task automatic miss_e(input string tag); step(1, 0, 1, 0, 0, tag); endtask
    task automatic miss_l(input string tag); step(1, 0, 0, 1, 0, tag); endtask
    task automatic idle(input string tag);  step(0, 1, 1, 1, 0, tag); endtask

    initial begin
        @(negedge clk);
        // Reset with garbage inputs
        for (int i = 0; i < 4; i++) begin
            step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), "reset_hold");
        end
        rst_n = 1'b1;
        model_reset();
        idle("after_reset");
        idle("after_reset");

        // Debounce rise with in_valid gaps
        for (int i = 0; i < NA; i++) begin
            hit("rise_hit");
            idle("rise_gap");
        end
        idle("rise_settle");
        for (int i = 0; i < ND; i++) miss_l("drop");
        hit("ggge_g"); hit("ggge_g"); hit("ggge_g"); miss_e("ggge_e"); hit("ggge_g");
        miss_l("back_idle");

        // Hysteresis: L,E,G,L,L,L,L while alarmed
        for (int i = 0; i < NA; i++) hit("hyst_arm");
        miss_l("hyst_l"); miss_e("hyst_e"); hit("hyst_glitch");
        for (int i = 0; i < ND; i++) miss_l("hyst_fall");
        idle("hyst_after");

        // Malformed code mid-arming, then clear
        hit("mal_arm"); hit("mal_arm");
        step(1, 1, 1, 0, 0, "mal_110");
        hit("mal_arm"); hit("mal_complete");
        step(0, 0, 0, 0, 1, "mal_clr");
        step(1, 0, 1, 1, 1, "mal_clr_set_wins");
        step(0, 0, 0, 0, 1, "mal_clr2");

        // Saturation of the event counter
        for (int k = 0; k < 260; k++) begin
            for (int i = 0; i < ND; i++) miss_e("sat_fall");
            for (int i = 0; i < NA; i++) hit("sat_rise");
        end
        for (int i = 0; i < ND; i++) miss_e("sat_drop");
        for (int i = 0; i < NA - 1; i++) hit("clr_rise_arm");
        step(1, 1, 0, 0, 1, "clr_with_rise");
        idle("clr_with_rise_after");

        // Async reset while disarming with two misses counted
        miss_l("disarm"); miss_l("disarm");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("async_reset_immediate");
        step(1, 0, 1, 0, 0, "async_reset_hold");
        rst_n = 1'b1;
        idle("async_reset_release");
        idle("async_reset_release");

        // Randomized traffic, mostly one-hot with occasional malformed codes and clears
        for (int i = 0; i < 3000; i++) begin
            bit v, g, e, l, c;
            int r;
            v = ($urandom_range(0, 9) < 8);
            r = $urandom_range(0, 31);
            if (r < 14)      begin g = 1; e = 0; l = 0; end
            else if (r < 22) begin g = 0; e = 1; l = 0; end
            else if (r < 30) begin g = 0; e = 0; l = 1; end
            else             begin g = 1'($urandom); e = 1'($urandom); l = 1; g = g | e; end
            c = ($urandom_range(0, 49) == 0);
            step(v, g, e, l, c, "random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
